// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 microcode sequencer: opcodes, control-word
// bit positions, microwords and T-state encodings.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // con bit positions, MSB first: {CP, EP, Lm_, CE_, Li_, ei_, La_, ea, Su, Eu, Lb_, Lo_}
    localparam int CON_CP  = 11;
    localparam int CON_EP  = 10;
    localparam int CON_LM  = 9;
    localparam int CON_CE  = 8;
    localparam int CON_LI  = 7;
    localparam int CON_EI  = 6;
    localparam int CON_LA  = 5;
    localparam int CON_EA  = 4;
    localparam int CON_SU  = 3;
    localparam int CON_EU  = 2;
    localparam int CON_LB  = 1;
    localparam int CON_LO  = 0;

    localparam logic [11:0] CON_IDLE    = 12'h3E3;
    localparam logic [11:0] CON_T1      = 12'h5E3;
    localparam logic [11:0] CON_T2      = 12'hBE3;
    localparam logic [11:0] CON_T3      = 12'h263;
    localparam logic [11:0] CON_MEM_T4  = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5  = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5  = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6  = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6  = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4  = 12'h3F2;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // One-hot mask of the last active T-state; NOP-class opcodes idle through T4.
    function automatic logic [5:0] last_t_mask(input logic [3:0] op);
        case (op)
            OP_LDA:         last_t_mask = T5;
            OP_ADD, OP_SUB: last_t_mask = T6;
            default:        last_t_mask = T4;
        endcase
    endfunction

endpackage

// File: rtl/sap_t_ring.sv
// One-hot six-state T ring. Advances on adv, loads T1 on restart or CLR,
// and holds while freeze is set.
module sap_t_ring
    import sap_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       adv,
    input  logic       restart,
    input  logic       freeze,
    output logic [5:0] t_state
);

    t_state_e state, state_nxt;

    always_ff @(posedge CLK) begin
        if (CLR) state <= T1;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (adv && !freeze) begin
            if (restart) begin
                state_nxt = T1;
            end else begin
                case (state)
                    T1:      state_nxt = T2;
                    T2:      state_nxt = T3;
                    T3:      state_nxt = T4;
                    T4:      state_nxt = T5;
                    T5:      state_nxt = T6;
                    default: state_nxt = T1;
                endcase
            end
        end
    end

    assign t_state = state;

endmodule

// File: rtl/sap_sequencer.sv
// SAP-1 microcode sequencer: run/step gated T-state engine with optional early
// end of short instructions, sticky halt and a retired-instruction counter.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [3:0]       opcode,
    input  logic             run,
    input  logic             step,
    output logic [11:0]      con,
    output logic [5:0]       t_state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    // Advance handshake: one T-state per clock whenever run or step is high and
    // not halted; with adv low the word is idle so no load or CP repeats.
    logic adv;
    logic is_hlt;
    logic hlt_edge;
    logic restart;
    logic done;

    assign adv      = (run | step) & ~halted;
    assign is_hlt   = (opcode == OP_HLT);
    assign hlt_edge = adv & t_state[T4_IDX] & is_hlt;
    assign restart  = adv & EARLY_END & ~is_hlt & ~t_state[T3_IDX]
                    & (|(t_state & last_t_mask(opcode)));
    assign done     = (restart | (adv & t_state[T6_IDX])) & ~hlt_edge;

    sap_t_ring u_ring (
        .CLK     (CLK),
        .CLR     (CLR),
        .adv     (adv),
        .restart (restart),
        .freeze  (hlt_edge),
        .t_state (t_state)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halted    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if (hlt_edge) halted <= 1'b1;
            if (done)     instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        con = CON_IDLE;
        if (adv) begin
            if (t_state[T1_IDX]) begin
                con = CON_T1;
            end else if (t_state[T2_IDX]) begin
                con = CON_T2;
            end else if (t_state[T3_IDX]) begin
                con = CON_T3;
            end else if (t_state[T4_IDX]) begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: con = CON_MEM_T4;
                    OP_OUT:                 con = CON_OUT_T4;
                    default:                con = CON_IDLE;
                endcase
            end else if (t_state[T5_IDX]) begin
                case (opcode)
                    OP_LDA:         con = CON_LDA_T5;
                    OP_ADD, OP_SUB: con = CON_ALU_T5;
                    default:        con = CON_IDLE;
                endcase
            end else if (t_state[T6_IDX]) begin
                case (opcode)
                    OP_ADD:  con = CON_ADD_T6;
                    OP_SUB:  con = CON_SUB_T6;
                    default: con = CON_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer with an early-end and a full-length instance.
module tb_sap_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        run = 1'b0;
    logic        step = 1'b0;

    logic [11:0] con1, con0;
    logic [5:0]  t1, t0;
    logic        h1, h0;
    logic [7:0]  cnt1, cnt0;

    int checks = 0;
    int failures = 0;
    int cp_seen;
    int su_eu_seen;

    sap_sequencer #(.EARLY_END(1'b1), .CNT_W(8)) dut1 (
        .CLK(CLK), .CLR(CLR), .opcode(opcode), .run(run), .step(step),
        .con(con1), .t_state(t1), .halted(h1), .instr_cnt(cnt1)
    );

    sap_sequencer #(.EARLY_END(1'b0), .CNT_W(8)) dut0 (
        .CLK(CLK), .CLR(CLR), .opcode(opcode), .run(run), .step(step),
        .con(con0), .t_state(t0), .halted(h0), .instr_cnt(cnt0)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        run = 1'b0;
        step = 1'b0;
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        logic [11:0] add_seq[6];
        logic [11:0] fetch_seq[3];
        add_seq   = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
        fetch_seq = '{12'h5E3, 12'hBE3, 12'h263};

        // Reset state
        do_reset();
        #1;
        check("rst_t", t1, 6'h01);
        check("rst_halt", h1, 1'b0);
        check("rst_cnt", cnt1, 8'd0);
        check("rst_con_idle", con1, 12'h3E3);

        // ADD with continuous run
        opcode = 4'h1;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("add_con_%0d", i), con1, add_seq[i]);
            tick();
        end
        check("add_t_back", t1, 6'h01);
        check("add_cnt", cnt1, 8'd1);
        check("add_next_t1", con1, 12'h5E3);

        // LDA (5 cycles) then OUT (4 cycles), early end
        do_reset();
        opcode = 4'h0;
        run = 1'b1;
        repeat (4) tick();
        check("lda_t5", t1, 6'h10);
        check("lda_t5_con", con1, 12'h2C3);
        tick();
        check("lda_back_t1", t1, 6'h01);
        opcode = 4'hE;
        repeat (3) tick();
        check("out_t4_con", con1, 12'h3F2);
        tick();
        check("out_back_t1", t1, 6'h01);
        check("lda_out_cnt", cnt1, 8'd2);

        // LDA with EARLY_END=0 runs all six states
        do_reset();
        opcode = 4'h0;
        run = 1'b1;
        repeat (5) tick();
        check("full_t6", t0, 6'h20);
        check("full_t6_con", con0, 12'h3E3);
        check("full_cnt_before", cnt0, 8'd0);
        tick();
        check("full_back_t1", t0, 6'h01);
        check("full_cnt", cnt0, 8'd1);

        // NOP: returns to T1 from T4 with early end
        do_reset();
        opcode = 4'h5;
        run = 1'b1;
        repeat (3) tick();
        check("nop_t4", t1, 6'h08);
        check("nop_t4_con", con1, 12'h3E3);
        tick();
        check("nop_back_t1", t1, 6'h01);
        check("nop_cnt", cnt1, 8'd1);

        // run and step together still advance once per clock
        do_reset();
        run = 1'b1;
        step = 1'b1;
        repeat (2) tick();
        check("run_step_t3", t1, 6'h04);

        // Single stepping with run=0
        do_reset();
        opcode = 4'h0;
        cp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            #1;
            if (con1[11]) cp_seen++;
            check($sformatf("step_con_%0d", k), con1, fetch_seq[k]);
            tick();
            step = 1'b0;
            for (int j = 0; j < 3; j++) begin
                #1;
                if (con1[11]) cp_seen++;
                check($sformatf("step_idle_%0d_%0d", k, j), con1, 12'h3E3);
                tick();
            end
            check($sformatf("step_t_%0d", k), t1, 6'h02 << k);
        end
        check("step_cp_once", cp_seen, 1);

        // HLT freezes at T4 until CLR
        do_reset();
        opcode = 4'hF;
        run = 1'b1;
        repeat (3) tick();
        check("hlt_t4_con", con1, 12'h3E3);
        check("hlt_pre", h1, 1'b0);
        tick();
        check("hlt_set", h1, 1'b1);
        check("hlt_set_full", h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step = i[0];
            #1;
            check($sformatf("hlt_con_%0d", i), con1, 12'h3E3);
            check($sformatf("hlt_t_%0d", i), t1, 6'h08);
            check($sformatf("hlt_cnt_%0d", i), cnt1, 8'd0);
            tick();
        end
        step = 1'b0;
        do_reset();
        check("hlt_clr_t", t1, 6'h01);
        check("hlt_clr_halt", h1, 1'b0);

        // CLR during SUB T5 aborts with no ALU pulse
        do_reset();
        opcode = 4'h2;
        run = 1'b1;
        su_eu_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (con1[3] | con1[2]) su_eu_seen++;
            tick();
        end
        check("sub_t5", t1, 6'h10);
        check("sub_t5_con", con1, 12'h2E1);
        CLR = 1'b1;
        #1;
        if (con1[3] | con1[2]) su_eu_seen++;
        tick();
        CLR = 1'b0;
        #1;
        if (con1[3] | con1[2]) su_eu_seen++;
        check("sub_clr_t", t1, 6'h01);
        check("sub_clr_cnt", cnt1, 8'd0);
        check("sub_clr_con", con1, 12'h5E3);
        check("sub_no_alu", su_eu_seen, 0);

        // Counter wraps after 256 OUT instructions
        do_reset();
        opcode = 4'hE;
        run = 1'b1;
        repeat (255 * 4) tick();
        check("cnt_255", cnt1, 8'd255);
        repeat (4) tick();
        check("cnt_wrap", cnt1, 8'd0);
        check("cnt_wrap_t", t1, 6'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Microcode sequencer for the SAP-1 datapath. It replaces the fixed six-state control path with a T-state engine that has three extra capabilities: run/single-step gating, optional early termination of short instructions, and a sticky halt. It drives the shared 12-bit control word that the PC, MAR, ROM, IR, A, ALU, B and Output units decode. It also exposes the current T-state and a retired-instruction count for debug.

## Interface
Parameters:
- `EARLY_END`, default 1: 1 = return to T1 after an instruction's last active T-state; 0 = always run T1–T6.
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `CLR` in 1: reset, synchronous, active-high.
- `opcode` in 4: IR upper nibble; valid from T4 onward.
- `run` in 1: level; 1 = advance one T-state per clock.
- `step` in 1: one-cycle pulse; advances exactly one T-state when `run`=0.
- `con` out 12: control word {CP, EP, Lm_, CE_, Li_, ei_, La_, ea, Su, Eu, Lb_, Lo_}, MSB first.
- `t_state` out 6: one-hot T-state, bit0 = T1.
- `halted` out 1: sticky halt flag.
- `instr_cnt` out CNT_W: number of completed instructions.

## Operation
- Idle word `CON_IDLE` = 0x3E3: all active-low loads/enables high, CP/EP/ea/Su/Eu low.
- `adv` = (`run` | `step`) & ~`halted`.
  - When `adv`=0: `con` = CON_IDLE and the T-state holds. This prevents repeated CP/loads while stalled.
- Fetch microwords (every opcode):
  - T1 = 0x5E3 (EP, Lm_)
  - T2 = 0xBE3 (CP)
  - T3 = 0x263 (CE_, Li_)
- Execute microwords by opcode:
  - LDA 0x0: T4 0x1A3 (Lm_, ei_); T5 0x2C3 (CE_, La_); T6 idle.
  - ADD 0x1: T4 0x1A3; T5 0x2E1 (CE_, Lb_); T6 0x3C7 (Eu, La_).
  - SUB 0x2: T4 0x1A3; T5 0x2E1; T6 0x3CF (Su, Eu, La_).
  - OUT 0xE: T4 0x3F2 (ea, Lo_); T5 and T6 idle.
  - HLT 0xF: T4 idle. On the T4 advance edge, set `halted`=1.
  - All other opcodes: NOP, idle in T4–T6.
- Last active state per opcode (used when EARLY_END=1): LDA T5, ADD/SUB T6, OUT T4, NOP T3.
  - With EARLY_END=1, the advance out of the last active state goes to T1.
  - With EARLY_END=0, the T-state always wraps T6→T1.
- `instr_cnt` increments on each advance edge that returns to T1. It wraps modulo 2^CNT_W. HLT does not increment it.
- `halted` is cleared only by `CLR`. While halted: `t_state` frozen at T4, `con` = CON_IDLE, and `run`/`step` are ignored.
- Opcode decoded during T3 uses early-termination rules for the NOP class only. The T3→T4 decision ignores `opcode`, except NOP, which is judged from the value present in T3.
  - Simplification, decided: with EARLY_END=1, T3 always advances to T4. A NOP then costs T4 as an idle state and returns to T1 from T4.
  - The NOP last active state is therefore T4.

## Timing
- Reset: `CLR`=1 at an edge gives next-cycle `t_state`=0x01, `halted`=0, `instr_cnt`=0. `con` shows the T1 word if `adv`, else 0x3E3.
- `CLR` mid-instruction aborts immediately; there is no completion or counter increment.
- `CLR` has priority over `run`/`step`/halt.
- `con` is combinational from the registered T-state, registered `opcode` context, and `adv`. Zero-cycle latency from `run`/`step` to `con`.
- `step` held high for N cycles = N advances; no edge detection.
- `run` and `step` both high = a single advance per clock.
- Instruction length in cycles under continuous `run`:
  - EARLY_END=1: LDA 5, ADD/SUB 6, OUT 4, NOP 4.
  - EARLY_END=0: all 6.

## Structure
- `sap_pkg` holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - `con` bit-index constants
  - CON_IDLE and all microword constants
  - T-state index constants
- Sub-module `sap_t_ring`: one-hot 6-bit ring counter with `adv`, `CLR` and a `restart` input (load T1), plus `freeze`.
- Decode logic and counters live in the top-level `sap_sequencer`.

## Test plan
- `CLR` then `run`=1, opcode=0x1 (ADD), EARLY_END=1 → `con` sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2E1, 0x3C7; `instr_cnt`=1 at the next T1.
- LDA then OUT with `run`=1 → LDA returns to T1 after 5 cycles and OUT after 4; `instr_cnt`=2.
- Same LDA with EARLY_END=0 → 6 cycles, T6 `con`=0x3E3.
- `run`=0 with three single `step` pulses spaced 4 cycles apart → `t_state` 0x01→0x02→0x04→0x08. `con`=0x3E3 on every non-step cycle; CP seen exactly once.
- opcode=0xF (HLT) → `halted`=1 after the T4 edge. Next 10 cycles: `con`=0x3E3, `t_state`=0x08, `instr_cnt` unchanged. `CLR` → `t_state`=0x01, `halted`=0.
- `CLR` asserted in T5 of SUB → next cycle T1, `instr_cnt`=0, no Su/Eu pulse observed.
